// File: rtl/fetch_line_unit.sv
// ---------------------------------------------------------------------------
// fetch_line_unit
//
// Instruction-fetch stage feeding decode. Fetches one cache-line-sized block
// (LINE_BEATS beats of 64 bits) over the system bus, buffers it, and then
// presents one 32-bit instruction per cycle together with its PC. Pipeline
// stalls freeze the presented instruction. Taken branches redirect the fetch
// PC and force a refetch; a line that is still arriving is drained first.
//
// Ports
//   clk           : clock, all state changes on posedge
//   reset_n       : asynchronous active-low reset
//   inStall       : decode cannot accept, hold outPc/outIns/outValid
//   inRedirect    : taken branch/jump, refetch from inRedirectPc
//   inRedirectPc  : redirect target (bits [1:0] ignored)
//   bus_req       : line request valid (registered)
//   bus_reqaddr   : line-aligned request address (registered)
//   bus_reqack    : bus accepted the request
//   bus_respcyc   : response beat valid
//   bus_resp      : response beat data
//   bus_respack   : response beat consumed (combinational)
//   outPc         : PC of outIns
//   outIns        : instruction to decode
//   outValid      : outPc/outIns valid
//   dbgState      : current FSM state (REQ=0 WAIT_ACK=1 RECV=2 SUPPLY=3 DRAIN=4)
//
// Handshakes
//   Request : bus_req rises with bus_reqaddr and both stay stable until a
//             cycle in which bus_req and bus_reqack are both high; that cycle
//             transfers the request and bus_req drops on the next edge.
//   Response: a beat transfers in every cycle in which bus_respcyc and
//             bus_respack are both high. bus_respack is only raised while a
//             line is outstanding (RECV or DRAIN with beats still owed), so
//             beats offered at any other time are left unconsumed.
// ---------------------------------------------------------------------------
module fetch_line_unit #(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter int                        LINE_BEATS     = 8,
  parameter logic [BUS_DATA_WIDTH-1:0] ENTRY_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inStall,
  input  logic                      inRedirect,
  input  logic [BUS_DATA_WIDTH-1:0] inRedirectPc,
  output logic                      bus_req,
  output logic [BUS_DATA_WIDTH-1:0] bus_reqaddr,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] outPc,
  output logic [31:0]               outIns,
  output logic                      outValid,
  output logic [2:0]                dbgState
);

  localparam int LINE_BYTES = LINE_BEATS * 8;
  localparam int OFF_BITS   = $clog2(LINE_BYTES);   // byte offset within a line
  localparam int WIDX_BITS  = OFF_BITS - 2;          // instruction index within a line
  localparam int BEAT_BITS  = $clog2(LINE_BEATS);
  localparam int CNT_BITS   = BEAT_BITS + 1;         // must be able to hold LINE_BEATS

  localparam logic [CNT_BITS-1:0]  LAST_BEAT = CNT_BITS'(LINE_BEATS - 1);
  localparam logic [CNT_BITS-1:0]  ALL_BEATS = CNT_BITS'(LINE_BEATS);
  localparam logic [WIDX_BITS-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {
    S_REQ      = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_RECV     = 3'd2,
    S_SUPPLY   = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t                      state;
  state_t                      stateNext;
  logic [BUS_DATA_WIDTH-1:0]   fetchPc;
  logic [CNT_BITS-1:0]         beatCnt;
  // A redirect seen while waiting for the request ack: the line still has to
  // be accepted and then thrown away.
  logic                        drainPend;
  logic [BUS_DATA_WIDTH-1:0]   lineBuf [LINE_BEATS];

  logic                        beatTake;
  logic                        issue;
  logic [WIDX_BITS-1:0]        wordIdx;
  logic [BUS_DATA_WIDTH-1:0]   selBeat;
  logic [31:0]                 selIns;
  logic [BUS_DATA_WIDTH-1:0]   lineAddr;
  logic [BUS_DATA_WIDTH-1:0]   redirPc;
  logic                        unusedPcBits;

  assign wordIdx  = fetchPc[OFF_BITS-1:2];
  assign lineAddr = {fetchPc[BUS_DATA_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign redirPc  = {inRedirectPc[BUS_DATA_WIDTH-1:2], 2'b00};
  assign unusedPcBits = ^inRedirectPc[1:0];

  // Each beat holds two instructions: low half is the lower address.
  assign selBeat = lineBuf[wordIdx[WIDX_BITS-1:1]];
  assign selIns  = wordIdx[0] ? selBeat[63:32] : selBeat[31:0];

  assign dbgState    = state;
  assign bus_respack = beatTake;

  // -------------------------------------------------------------------------
  // Next-state and per-cycle control
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    beatTake  = 1'b0;
    issue     = 1'b0;
    case (state)
      S_REQ: begin
        // A redirect here only retargets fetchPc; the request goes out once
        // the redirect has settled.
        if (!inRedirect) stateNext = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus_reqack) begin
          stateNext = (drainPend || inRedirect) ? S_DRAIN : S_RECV;
        end
      end
      S_RECV: begin
        beatTake = bus_respcyc;
        if (inRedirect) begin
          stateNext = S_DRAIN;
        end else if (bus_respcyc && (beatCnt == LAST_BEAT)) begin
          stateNext = S_SUPPLY;
        end
      end
      S_SUPPLY: begin
        if (inRedirect) begin
          stateNext = S_REQ;
        end else if (!inStall) begin
          issue = 1'b1;
          if (wordIdx == LAST_WORD) stateNext = S_REQ;
        end
      end
      S_DRAIN: begin
        // Beat counter already at ALL_BEATS means the redirect coincided with
        // the final beat: nothing is owed, move straight on.
        beatTake = bus_respcyc && (beatCnt != ALL_BEATS);
        if ((beatCnt == ALL_BEATS) || (bus_respcyc && (beatCnt == LAST_BEAT))) begin
          stateNext = S_REQ;
        end
      end
      default: stateNext = S_REQ;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, bus request and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_REQ;
      fetchPc     <= ENTRY_PC;
      beatCnt     <= '0;
      drainPend   <= 1'b0;
      bus_req     <= 1'b0;
      bus_reqaddr <= '0;
      outValid    <= 1'b0;
      outIns      <= '0;
      outPc       <= '0;
    end else begin
      state <= stateNext;

      if ((state == S_REQ) && (stateNext == S_WAIT_ACK)) begin
        bus_req     <= 1'b1;
        bus_reqaddr <= lineAddr;
        beatCnt     <= '0;
        drainPend   <= 1'b0;
      end else if ((state == S_WAIT_ACK) && bus_reqack) begin
        bus_req <= 1'b0;
      end

      if ((state == S_WAIT_ACK) && inRedirect) drainPend <= 1'b1;

      if (beatTake) beatCnt <= beatCnt + 1'b1;

      // Redirect beats stall; stall freezes everything on the decode side.
      if (inRedirect) begin
        fetchPc  <= redirPc;
        outValid <= 1'b0;
      end else if (issue) begin
        outIns   <= selIns;
        outPc    <= fetchPc;
        outValid <= 1'b1;
        fetchPc  <= fetchPc + BUS_DATA_WIDTH'(4);
      end else if (!inStall) begin
        outValid <= 1'b0;
      end
    end
  end

  // Line buffer: data storage only, contents are meaningless until a full
  // line has been received, so it carries no reset. Drained beats are not
  // written.
  always_ff @(posedge clk) begin
    if ((state == S_RECV) && bus_respcyc) begin
      lineBuf[beatCnt[BEAT_BITS-1:0]] <= bus_resp;
    end
  end

endmodule

// File: tb/tb_fetch_line_unit.sv
module tb_fetch_line_unit;

  localparam int W = 64;

  // ---------------------------------------------------------------------
  // Clock / reset and shared stimulus
  // ---------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         inStall = 1'b0;
  logic         inRedirect = 1'b0;
  logic [W-1:0] inRedirectPc = '0;
  logic         bus_reqack = 1'b0;
  logic         bus_respcyc = 1'b0;
  logic [W-1:0] bus_resp = '0;

  always #5 clk = ~clk;

  // Instance A: ENTRY_PC = 0x100
  logic         aReq;
  logic [W-1:0] aReqAddr;
  logic         aRespAck;
  logic [W-1:0] aPc;
  logic [31:0]  aIns;
  logic         aValid;
  logic [2:0]   aState;

  // Instance B: ENTRY_PC = 0x108 (mid-line entry), same stimulus as A
  logic         bReq;
  logic [W-1:0] bReqAddr;
  logic         bRespAck;
  logic [W-1:0] bPc;
  logic [31:0]  bIns;
  logic         bValid;
  logic [2:0]   bState;

  fetch_line_unit #(.ENTRY_PC(64'h100)) dutA (
    .clk(clk), .reset_n(reset_n), .inStall(inStall), .inRedirect(inRedirect),
    .inRedirectPc(inRedirectPc), .bus_req(aReq), .bus_reqaddr(aReqAddr),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_respack(aRespAck), .outPc(aPc), .outIns(aIns), .outValid(aValid),
    .dbgState(aState)
  );

  fetch_line_unit #(.ENTRY_PC(64'h108)) dutB (
    .clk(clk), .reset_n(reset_n), .inStall(inStall), .inRedirect(inRedirect),
    .inRedirectPc(inRedirectPc), .bus_req(bReq), .bus_reqaddr(bReqAddr),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_respack(bRespAck), .outPc(bPc), .outIns(bIns), .outValid(bValid),
    .dbgState(bState)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int           nVec = 0;
  int           nMiss = 0;
  logic [95:0]  expQ[$];   // {pc, instruction}

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction word stored at index idx of the line tagged "tag".
  function automatic logic [31:0] insVal(input int tag, input int idx);
    return 32'(tag * 256 + idx);
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n     = 1'b0;
    inStall     = 1'b0;
    inRedirect  = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for A's request, check it, hold for 'delay' cycles, ack.
  task automatic serveReq(input logic [63:0] addr, input int delay);
    int n;
    n = 0;
    while (!aReq && n < 20) begin
      tick();
      n++;
    end
    checkVal("req_seen", 64'(aReq), 64'd1);
    checkVal("req_addr", aReqAddr, addr);
    repeat (delay) begin
      tick();
      checkVal("req_hold", 64'(aReq), 64'd1);
      checkVal("req_hold_addr", aReqAddr, addr);
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    checkVal("req_drop", 64'(aReq), 64'd0);
  endtask

  task automatic sendBeats(input int tag, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = {insVal(tag, 2 * k + 1), insVal(tag, 2 * k)};
      #1;
      checkVal("resp_ack", 64'(aRespAck), 64'd1);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
  endtask

  task automatic popCheck();
    logic [95:0] e;
    e = expQ.pop_front();
    checkVal("out_valid", 64'(aValid), 64'd1);
    checkVal("out_pc", aPc, e[95:32]);
    checkVal("out_ins", 64'(aIns), 64'(e[31:0]));
  endtask

  task automatic expectIssue(input logic [63:0] pc, input int tag);
    expQ.push_back({pc, insVal(tag, int'(pc[5:2]))});
    tick();
    popCheck();
  endtask

  task automatic redirectTo(input logic [63:0] pc);
    inRedirect   = 1'b1;
    inRedirectPc = pc;
    tick();
    inRedirect   = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  int nB;

  initial begin
    // Reset state
    doReset();
    reset_n = 1'b0;
    #1;
    checkVal("rst_req", 64'(aReq), 64'd0);
    checkVal("rst_addr", aReqAddr, 64'd0);
    checkVal("rst_respack", 64'(aRespAck), 64'd0);
    checkVal("rst_valid", 64'(aValid), 64'd0);
    checkVal("rst_ins", 64'(aIns), 64'd0);
    checkVal("rst_pc", aPc, 64'd0);
    checkVal("rst_state", 64'(aState), 64'd0);
    checkVal("rst_b_req", 64'(bReq), 64'd0);
    checkVal("rst_b_valid", 64'(bValid), 64'd0);
    reset_n = 1'b1;

    // Full line from 0x100 (A) and mid-line entry at 0x108 (B)
    serveReq(64'h100, 1);
    checkVal("b_req_addr", bReqAddr, 64'h100);
    sendBeats(0, 0, 7);
    checkVal("valid_before_supply", 64'(aValid), 64'd0);
    for (int i = 0; i < 16; i++) expQ.push_back({64'h100 + 64'(4 * i), insVal(0, i)});
    nB = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      popCheck();
      if (bValid) nB++;
      if (i < 14) begin
        checkVal("b_pc", bPc, 64'h108 + 64'(4 * i));
        checkVal("b_ins", 64'(bIns), 64'(insVal(0, i + 2)));
      end else if (i == 14) begin
        checkVal("b_valid_end", 64'(bValid), 64'd0);
        checkVal("b_next_req", 64'(bReq), 64'd1);
        checkVal("b_next_addr", bReqAddr, 64'h140);
      end
      // Stray beat outside RECV/DRAIN must not be consumed.
      bus_respcyc = 1'b1;
      bus_resp    = '1;
      #1;
      checkVal("stray_ack", 64'(aRespAck), 64'd0);
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    checkVal("b_issued", 64'(nB), 64'd14);
    tick();
    checkVal("a_valid_end", 64'(aValid), 64'd0);
    checkVal("a_next_req", 64'(aReq), 64'd1);
    checkVal("a_next_addr", aReqAddr, 64'h140);

    // Stall for 3 cycles at 0x110
    doReset();
    serveReq(64'h100, 0);
    sendBeats(0, 0, 7);
    for (int i = 0; i <= 4; i++) expectIssue(64'h100 + 64'(4 * i), 0);
    inStall = 1'b1;
    repeat (3) expectIssue(64'h110, 0);
    inStall = 1'b0;
    for (int i = 5; i <= 8; i++) expectIssue(64'h100 + 64'(4 * i), 0);

    // Redirect (with simultaneous stall) at 0x120 to 0x2006
    inStall = 1'b1;
    redirectTo(64'h2006);
    inStall = 1'b0;
    checkVal("redir_valid", 64'(aValid), 64'd0);
    checkVal("redir_state", 64'(aState), 64'd0);
    serveReq(64'h2000, 2);
    sendBeats(32, 0, 7);
    checkVal("redir_valid_fill", 64'(aValid), 64'd0);
    expectIssue(64'h2004, 32);
    expectIssue(64'h2008, 32);

    // Redirect during RECV after beat 3: remaining beats drained
    redirectTo(64'h3000);
    serveReq(64'h3000, 0);
    sendBeats(48, 0, 3);
    redirectTo(64'h400);
    checkVal("drain_state", 64'(aState), 64'd4);
    checkVal("drain_valid", 64'(aValid), 64'd0);
    sendBeats(48, 4, 7);
    checkVal("drain_done_state", 64'(aState), 64'd0);
    checkVal("drain_done_valid", 64'(aValid), 64'd0);
    serveReq(64'h400, 0);
    sendBeats(4, 0, 7);
    expectIssue(64'h400, 4);
    expectIssue(64'h404, 4);

    // Redirect coinciding with the final beat
    redirectTo(64'h500);
    serveReq(64'h500, 0);
    sendBeats(5, 0, 6);
    bus_respcyc  = 1'b1;
    bus_resp     = {insVal(5, 15), insVal(5, 14)};
    inRedirect   = 1'b1;
    inRedirectPc = 64'h600;
    #1;
    checkVal("last_beat_ack", 64'(aRespAck), 64'd1);
    tick();
    inRedirect = 1'b0;
    bus_resp   = '1;
    #1;
    checkVal("drain_empty_ack", 64'(aRespAck), 64'd0);
    checkVal("drain_empty_state", 64'(aState), 64'd4);
    tick();
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    checkVal("drain_empty_exit", 64'(aState), 64'd0);
    serveReq(64'h600, 0);
    sendBeats(6, 0, 7);
    expectIssue(64'h600, 6);

    // Redirect while waiting for ack: request completes, line drained
    redirectTo(64'h700);
    tick();
    checkVal("wack_req", 64'(aReq), 64'd1);
    checkVal("wack_addr", aReqAddr, 64'h700);
    redirectTo(64'h800);
    checkVal("wack_req_held", 64'(aReq), 64'd1);
    checkVal("wack_addr_held", aReqAddr, 64'h700);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    checkVal("wack_drain", 64'(aState), 64'd4);
    checkVal("wack_req_drop", 64'(aReq), 64'd0);
    sendBeats(7, 0, 7);
    checkVal("wack_drain_exit", 64'(aState), 64'd0);
    serveReq(64'h800, 0);
    sendBeats(8, 0, 7);
    expectIssue(64'h800, 8);

    // Asynchronous reset in the middle of RECV
    redirectTo(64'h900);
    serveReq(64'h900, 0);
    sendBeats(9, 0, 2);
    bus_respcyc = 1'b1;
    bus_resp    = '1;
    reset_n     = 1'b0;
    #1;
    checkVal("arst_req", 64'(aReq), 64'd0);
    checkVal("arst_addr", aReqAddr, 64'd0);
    checkVal("arst_respack", 64'(aRespAck), 64'd0);
    checkVal("arst_valid", 64'(aValid), 64'd0);
    checkVal("arst_ins", 64'(aIns), 64'd0);
    checkVal("arst_pc", aPc, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkVal("arst_rereq", 64'(aReq), 64'd1);
    checkVal("arst_rereq_addr", aReqAddr, 64'h100);
    checkVal("arst_stale_ack", 64'(aRespAck), 64'd0);
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    serveReq(64'h100, 0);
    sendBeats(0, 0, 7);
    expectIssue(64'h100, 0);
    expectIssue(64'h104, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_line_unit.md
Name: fetch_line_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Requests one 64-byte line over the system bus and buffers the 8 returned 64-bit beats (16 instructions).
- Presents one instruction per cycle, with its PC, to decode.
- Stalls on request from the pipeline; redirects on a taken branch.

Parameters:
- BUS_DATA_WIDTH, 64, bus data and PC width.
- LINE_BEATS, 8, beats per line (line size = LINE_BEATS*8 bytes).
- ENTRY_PC, 64'h0, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- inStall  input  1  decode cannot accept; hold current outputs.
- inRedirect  input  1  taken branch or jump; refetch from inRedirectPc.
- inRedirectPc  input  BUS_DATA_WIDTH  redirect target; bits[1:0] ignored.
- bus_req  output  1  line request valid.
- bus_reqaddr  output  BUS_DATA_WIDTH  line-aligned request address.
- bus_reqack  input  1  bus accepted request.
- bus_respcyc  input  1  response beat valid.
- bus_resp  input  BUS_DATA_WIDTH  response beat data.
- bus_respack  output  1  beat consumed.
- outPc  output  BUS_DATA_WIDTH  PC of outIns.
- outIns  output  32  instruction to decode.
- outValid  output  1  outIns/outPc valid.

Behaviour:
- Reset (async assert, sync release), all outputs:
  - bus_req=0, bus_reqaddr=0, bus_respack=0, outValid=0, outIns=0, outPc=0.
  - fetchPc=ENTRY_PC, beat counter=0, state=REQ.
- States: REQ, WAIT_ACK, RECV, SUPPLY, DRAIN.
- REQ:
  - Drive bus_req=1 and bus_reqaddr = fetchPc with bits[5:0] cleared; go to WAIT_ACK next cycle.
- WAIT_ACK:
  - Hold bus_req/addr until bus_reqack=1, then drop bus_req and go to RECV.
  - bus_req is held stable; never withdrawn before ack.
- RECV:
  - Each cycle with bus_respcyc=1, store bus_resp into buffer[counter], set bus_respack=1 in the same cycle, and increment the counter.
  - After beat LINE_BEATS-1, go to SUPPLY.
- Beat layout: beat k [31:0] = instruction at line+8k; [63:32] = line+8k+4.
- SUPPLY:
  - Each non-stalled cycle, register outIns = buffer word at fetchPc[5:2], outPc = fetchPc, outValid=1; then fetchPc += 4.
  - The instruction at fetchPc appears on outputs 1 cycle after SUPPLY entry.
  - When the word just issued was index 15, go to REQ for the next sequential line; outValid=0 from the next cycle until the new line supplies.
- Stall:
  - inStall=1 freezes outIns/outPc/outValid and fetchPc, in every state.
  - Bus activity (REQ/WAIT_ACK/RECV) proceeds regardless of stall.
- Redirect (priority over stall):
  - fetchPc <= {inRedirectPc[63:2],2'b00}; outValid=0 next cycle.
  - From SUPPLY or REQ: go to REQ.
  - From WAIT_ACK: request still completes; go to DRAIN after ack.
  - From RECV: go to DRAIN.
  - DRAIN consumes (acks) all remaining beats of the outstanding line, discards them, then goes to REQ.
- No line reuse: a redirect always refetches, even if the target is in the buffered line.
- Simultaneous inRedirect and inStall: redirect wins.
- Simultaneous redirect and final beat: DRAIN sees 0 remaining beats and goes directly to REQ.
- bus_respcyc outside RECV/DRAIN is ignored; bus_respack=0.
- Entry mid-line: ENTRY_PC=0x108 requests line 0x100; the first issued word is index 2.
- Throughput: 1 instruction/cycle in SUPPLY. Bus latency is exposed on every line change (no prefetch).

Test Plan:
1. ENTRY_PC=0x100, release reset, ack after 2 cycles, 8 beats beat k={k*2+1,k*2} -> bus_reqaddr=0x100 once; outPc 0x100..0x13C with outIns 0..15 on consecutive cycles; then bus_req with addr 0x140.
2. ENTRY_PC=0x108, same line -> first outValid shows outPc=0x108, outIns=2; 14 instructions issued before the next request to 0x140.
3. During SUPPLY at outPc=0x110, inStall high 3 cycles -> outPc=0x110/outIns=4 held 3 extra cycles; resumes at 0x114.
4. inRedirect with inRedirectPc=0x2006 at outPc=0x120 -> outValid=0 next cycle; request addr 0x2000; first output outPc=0x2004, outIns=buffer word 1.
5. inRedirect to 0x400 after beat 3 of RECV -> beats 4..7 acked and discarded; next bus_reqaddr=0x400; no instruction from the old line issued.
6. reset_n low mid-RECV -> all outputs 0 immediately (async); after release, bus_req reissued to ENTRY_PC line; stale beats ignored.
